// File: rtl/epoch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// epoch_seq_pkg
// Shared types and constants for the epoch sequencer:
//   - seq_state_e : sequencer FSM state encoding
//   - order_tbl() : spike-order table; row p is 0..NUM_CH-1 rotated left by p
//   - label_of()  : pattern-index to class-label mapping
//   - LFSR_SEED / LFSR_TAPS / lfsr_step() : pattern-shuffle LFSR, only used
//     when the block is built with EPOCH_SHUFFLE_EN
// -----------------------------------------------------------------------------
package epoch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPIKE     = 3'd1,
    S_GAP       = 3'd2,
    S_LBL_WAIT  = 3'd3,
    S_LABEL     = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_NEXT      = 3'd6,
    S_DONE      = 3'd7
  } seq_state_e;

  localparam int unsigned PAT_IDX_W = 4;
  localparam int unsigned EPOCH_W   = 16;

  // Galois form, right-shifting: taps 16,14,13,11 -> mask 0xB400.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Channel fired by slot `slot` of pattern `pat`. The table is a pure
  // rotation, so it is generated arithmetically rather than stored.
  function automatic int unsigned order_tbl(input int unsigned pat,
                                            input int unsigned slot,
                                            input int unsigned num_ch);
    return (pat + slot) % num_ch;
  endfunction

  function automatic int unsigned label_of(input int unsigned pat,
                                           input int unsigned num_classes);
    return pat % num_classes;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/epoch_sequencer_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter
// Loadable down counter shared by the GAP and LBL_WAIT phases.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load i_load_val (wins over i_dec)
//   i_dec          : decrement by one, stops at zero
//   o_term         : counter currently holds 1 (last wait cycle)
// -----------------------------------------------------------------------------
module seq_down_counter #(
  parameter int unsigned W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_term
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load)                    cnt_d = i_load_val;
    else if (i_dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Terminal at 1 so a load of N yields exactly N wait cycles.
  assign o_term = (cnt_q == W'(1));

endmodule

// File: rtl/epoch_sequencer.sv
// -----------------------------------------------------------------------------
// epoch_sequencer
// Runs the supervised training schedule: each epoch replays NUM_PAT fixed
// spike patterns into the input layer, pulses the class label after each
// pattern, waits for the network's done handshake, and flags end of training
// after NUM_EPOCHS epochs.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          pulse, starts training from IDLE or DONE
//   i_pause          level, holds the sequencer between patterns
//   i_net_done       pulse, network finished its update for this pattern
//   o_spike          one-hot spike event, one cycle, only in SPIKE
//   o_label          one-cycle label-valid pulse
//   o_label_id       class of the current pattern, held until next label
//   o_busy           high outside IDLE and DONE
//   o_pattern_idx    index of the pattern being presented
//   o_epoch_cnt      completed epochs (saturates at NUM_EPOCHS)
//   o_end_of_epochs  high in DONE
//
// Build option: define EPOCH_SHUFFLE_EN to rotate the pattern order per epoch
// by an LFSR-derived offset. Undefined, patterns run 0..NUM_PAT-1 in order.
// -----------------------------------------------------------------------------
module epoch_sequencer
  import epoch_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_PAT     = 4,
  parameter int unsigned NUM_CLASSES = 2,
  parameter int unsigned NUM_EPOCHS  = 100,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned LABEL_DELAY = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_net_done,
  output logic [NUM_CH-1:0]      o_spike,
  output logic                   o_label,
  output logic [((NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1)-1:0] o_label_id,
  output logic                   o_busy,
  output logic [PAT_IDX_W-1:0]   o_pattern_idx,
  output logic [EPOCH_W-1:0]     o_epoch_cnt,
  output logic                   o_end_of_epochs
);

  localparam int unsigned LID_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CMAX   = (GAP_CYCLES > LABEL_DELAY) ? GAP_CYCLES : LABEL_DELAY;
  localparam int unsigned CNT_W  = $clog2(CMAX + 1);

  seq_state_e           state_q, state_d;
  logic [PAT_IDX_W-1:0] pat_q, pat_d;        // local (unshuffled) pattern index
  logic [SLOT_W-1:0]    slot_q, slot_d;      // spike slot within the pattern
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 done_flag_q, done_flag_d;
  logic [LID_W-1:0]     label_id_q, label_id_d;

  logic                 cnt_load, cnt_dec, cnt_term;
  logic [CNT_W-1:0]     cnt_val;
  logic                 start_acc;           // i_start accepted this cycle
  logic                 epoch_adv;           // NEXT leaving the last pattern
  logic [PAT_IDX_W-1:0] pres_pat;            // pattern actually presented
  logic [LID_W-1:0]     lbl_cur;
  logic [SLOT_W-1:0]    spk_ch;
  logic [EPOCH_W-1:0]   epoch_inc;

  // ---------------------------------------------------------------------------
  // Presented-pattern mapping
  // ---------------------------------------------------------------------------
`ifdef EPOCH_SHUFFLE_EN
  logic [15:0]          lfsr_q, lfsr_d;
  logic [PAT_IDX_W-1:0] offset_q, offset_d;

  // Offset is latched at epoch start from the freshly stepped LFSR; the first
  // epoch after i_start always runs unrotated.
  always_comb begin
    lfsr_d   = lfsr_q;
    offset_d = offset_q;
    if (start_acc) begin
      offset_d = '0;
    end else if (epoch_adv) begin
      lfsr_d   = lfsr_step(lfsr_q);
      offset_d = PAT_IDX_W'(32'(lfsr_d[3:0]) % NUM_PAT);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q   <= LFSR_SEED;
      offset_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      offset_q <= offset_d;
    end
  end

  assign pres_pat = PAT_IDX_W'((32'(pat_q) + 32'(offset_q)) % NUM_PAT);
`else
  assign pres_pat = pat_q;
`endif

  assign lbl_cur   = LID_W'(label_of(32'(pres_pat), NUM_CLASSES));
  assign spk_ch    = SLOT_W'(order_tbl(32'(pres_pat), 32'(slot_q), NUM_CH));
  assign epoch_inc = (epoch_q == EPOCH_W'(NUM_EPOCHS)) ? epoch_q : epoch_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Wait counter for GAP and LBL_WAIT
  // ---------------------------------------------------------------------------
  assign cnt_dec = (state_q == S_GAP) || (state_q == S_LBL_WAIT);

  seq_down_counter #(.W(CNT_W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .i_dec      (cnt_dec),
    .o_term     (cnt_term)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    slot_d      = slot_q;
    epoch_d     = epoch_q;
    done_flag_d = done_flag_q;
    label_id_d  = label_id_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    start_acc   = 1'b0;
    epoch_adv   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          start_acc   = 1'b1;
          state_d     = S_SPIKE;
          pat_d       = '0;
          slot_d      = '0;
          epoch_d     = '0;
          done_flag_d = 1'b0;
        end
      end

      S_SPIKE: begin
        cnt_load = 1'b1;
        if (32'(slot_q) < NUM_CH - 1) begin
          cnt_val = CNT_W'(GAP_CYCLES);
          state_d = S_GAP;
        end else begin
          cnt_val = CNT_W'(LABEL_DELAY);
          state_d = S_LBL_WAIT;
        end
      end

      // Pause is deliberately not honoured here: a pattern, once started, is
      // always emitted with its nominal spike spacing.
      S_GAP: begin
        if (cnt_term) begin
          state_d = S_SPIKE;
          slot_d  = slot_q + 1'b1;
        end
      end

      S_LBL_WAIT: begin
        if (cnt_term) state_d = S_LABEL;
      end

      // A done pulse coinciding with the label is remembered so WAIT_DONE
      // does not stall for a second handshake.
      S_LABEL: begin
        label_id_d  = lbl_cur;
        done_flag_d = i_net_done;
        state_d     = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (i_net_done || done_flag_q) begin
          done_flag_d = 1'b0;
          state_d     = S_NEXT;
        end
      end

      S_NEXT: begin
        if (!i_pause) begin
          slot_d = '0;
          if (32'(pat_q) < NUM_PAT - 1) begin
            pat_d   = pat_q + 1'b1;
            state_d = S_SPIKE;
          end else begin
            epoch_adv = 1'b1;
            pat_d     = '0;
            epoch_d   = epoch_inc;
            state_d   = (epoch_inc == EPOCH_W'(NUM_EPOCHS)) ? S_DONE : S_SPIKE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      slot_q      <= '0;
      epoch_q     <= '0;
      done_flag_q <= 1'b0;
      label_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      slot_q      <= slot_d;
      epoch_q     <= epoch_d;
      done_flag_q <= done_flag_d;
      label_id_q  <= label_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state, so reset clears them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_spike = '0;
    if (state_q == S_SPIKE) o_spike[spk_ch] = 1'b1;
  end

  assign o_label         = (state_q == S_LABEL);
  assign o_label_id      = (state_q == S_LABEL) ? lbl_cur : label_id_q;
  assign o_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_pattern_idx   = pres_pat;
  assign o_epoch_cnt     = epoch_q;
  assign o_end_of_epochs = (state_q == S_DONE);

endmodule
